// File: rtl/seg_pkg.sv
// Shared types and glyph table for the seven-segment scanner.
// Patterns are stored low-active, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

    typedef logic [6:0] seg7_t;

    typedef enum logic {
        SLOT_BLANK = 1'b0,
        SLOT_DRIVE = 1'b1
    } slot_state_t;

    localparam seg7_t SEG_OFF = 7'b1111111;

    localparam seg7_t HEX_SEG [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to seven-segment pattern decoder.
// ACTIVE_LOW selects whether lit segments are driven 0 (1) or 1 (0).
module seg_hex_decode
    import seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = ACTIVE_LOW ? HEX_SEG[nibble] : ~HEX_SEG[nibble];

endmodule

// File: rtl/seg_display_scan.sv
// Time-multiplexed N-digit seven-segment scanner with blanking and a frame-committed shadow.
// Build option SEG_LZ_BLANK_EN enables leading-zero suppression on the committed value.
module seg_display_scan
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 65536,
    parameter int BLANK_CYCLES = 256,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_pulse,
    output logic                    pending
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0]         CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]         BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [6:0]            SEG_IDLE  = ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;
    localparam logic                  DP_ON     = !ACTIVE_LOW;

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;

    logic [4*NUM_DIGITS-1:0] value_s, value_c;
    logic [NUM_DIGITS-1:0]   dp_s, dp_c;
    logic [NUM_DIGITS-1:0]   en_s, en_c;
    logic [NUM_DIGITS-1:0]   show;

    logic                  wrap, boundary;
    slot_state_t           slot_state;
    logic [3:0]            cur_nib;
    logic                  cur_dp, lit;
    logic [6:0]            dec_seg, seg_d;
    logic                  dp_d;
    logic [NUM_DIGITS-1:0] anode_d;

    assign wrap     = (cnt == CNT_LAST);
    assign boundary = wrap && (idx == IDX_LAST);

`ifdef SEG_LZ_BLANK_EN
    // Scanning down from the top, a digit stays lit once any digit at or above it
    // carries a nonzero nibble or a decimal point; digit 0 is never suppressed.
    always_comb begin : lz_mask
        logic keep;
        keep = 1'b0;
        show = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            keep    = keep | (value_c[4*i +: 4] != 4'h0) | dp_c[i] | (i == 0);
            show[i] = keep;
        end
    end
`else
    assign show = {NUM_DIGITS{1'b1}};
`endif

    always_comb begin
        slot_state = (cnt < BLANK_END) ? SLOT_BLANK : SLOT_DRIVE;
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        lit        = 1'b0;
        anode_d    = ANODE_OFF;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (int'(idx) == i) begin
                cur_nib = value_c[4*i +: 4];
                cur_dp  = dp_c[i];
                lit     = (slot_state == SLOT_DRIVE) && en_c[i] && show[i];
                if (lit) anode_d[i] = ~ANODE_OFF[i];
            end
        end
    end

    seg_hex_decode #(
        .ACTIVE_LOW(ACTIVE_LOW)
    ) u_hex_decode (
        .nibble(cur_nib),
        .seg   (dec_seg)
    );

    always_comb begin
        seg_d = SEG_IDLE;
        dp_d  = !DP_ON;
        if (lit) begin
            seg_d = dec_seg;
            if (cur_dp) dp_d = DP_ON;
        end
    end

    // A load on the boundary cycle bypasses the shadow so it is shown next frame.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt         <= '0;
            idx         <= '0;
            value_s     <= '0;
            dp_s        <= '0;
            en_s        <= '0;
            value_c     <= '0;
            dp_c        <= '0;
            en_c        <= '0;
            pending     <= 1'b0;
            frame_pulse <= 1'b0;
            anode       <= ANODE_OFF;
            seg_out     <= SEG_IDLE;
            dp_out      <= !DP_ON;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

            if (load) begin
                value_s <= value;
                dp_s    <= dp_in;
                en_s    <= digit_en;
            end

            if (boundary) begin
                frame_pulse <= 1'b1;
                pending     <= 1'b0;
                if (load) begin
                    value_c <= value;
                    dp_c    <= dp_in;
                    en_c    <= digit_en;
                end else if (pending) begin
                    value_c <= value_s;
                    dp_c    <= dp_s;
                    en_c    <= en_s;
                end
            end else begin
                frame_pulse <= 1'b0;
                if (load) pending <= 1'b1;
            end

            anode   <= anode_d;
            seg_out <= seg_d;
            dp_out  <= dp_d;
        end
    end

endmodule

// File: tb/tb_seg_display_scan.sv
// Bench for seg_display_scan: frame-position reference model plus directed and random loads.
// Configured with 4 digits, 8-cycle slots, 2 blank cycles, low-active outputs.
module tb_seg_display_scan;

  localparam int ND = 4;
  localparam int DIV = 8;
  localparam int BLK = 2;
  localparam int FRAME = ND * DIV;

  logic clk;
  logic clr;
  logic load;
  logic [4*ND-1:0] value;
  logic [ND-1:0] dp_in;
  logic [ND-1:0] digit_en;
  logic [6:0] seg_out;
  logic dp_out;
  logic [ND-1:0] anode;
  logic frame_pulse;
  logic pending;

  int checks = 0;
  int errors = 0;

  seg_display_scan #(
    .NUM_DIGITS(ND),
    .CLK_DIV(DIV),
    .BLANK_CYCLES(BLK),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .clr(clr),
    .load(load),
    .value(value),
    .dp_in(dp_in),
    .digit_en(digit_en),
    .seg_out(seg_out),
    .dp_out(dp_out),
    .anode(anode),
    .frame_pulse(frame_pulse),
    .pending(pending)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Active-high glyphs {g,f,e,d,c,b,a}; the panel lights a segment by driving it low.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0111111;
      4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;
      4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;
      4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;
      4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;
      4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;
      4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;
      default: return 7'b1110001;
    endcase
  endfunction

  // reference model: position within the frame plus committed/shadow contents
  logic [4*ND-1:0] m_val_c, m_val_s;
  logic [ND-1:0] m_dp_c, m_dp_s, m_en_c, m_en_s;
  bit m_pend;
  bit m_valid = 1'b0;
  int m_pos;
  logic [ND-1:0] e_anode;
  logic [6:0] e_seg;
  logic e_dp, e_fp;

  function automatic bit m_shown(input int d);
    int top;
    top = ND - 1;
`ifdef SEG_LZ_BLANK_EN
    top = 0;
    for (int i = 0; i < ND; i++)
      if (m_val_c[4*i +: 4] != 4'h0 || m_dp_c[i]) top = i;
`endif
    return d <= top;
  endfunction

  always @(posedge clk) begin
    if (clr) begin
      m_valid <= 1'b1;
      m_pos <= 0;
      m_val_c <= '0; m_val_s <= '0;
      m_dp_c <= '0; m_dp_s <= '0;
      m_en_c <= '0; m_en_s <= '0;
      m_pend <= 1'b0;
      e_anode <= '1; e_seg <= 7'h7F; e_dp <= 1'b1; e_fp <= 1'b0;
    end else if (m_valid) begin
      if ((m_pos % DIV) >= BLK && m_en_c[m_pos / DIV] && m_shown(m_pos / DIV)) begin
        e_anode <= ~(4'b0001 << (m_pos / DIV));
        e_seg <= ~glyph(m_val_c[4*(m_pos / DIV) +: 4]);
        e_dp <= ~m_dp_c[m_pos / DIV];
      end else begin
        e_anode <= '1; e_seg <= 7'h7F; e_dp <= 1'b1;
      end
      if (load) begin
        m_val_s <= value; m_dp_s <= dp_in; m_en_s <= digit_en;
      end
      if (m_pos == FRAME - 1) begin
        e_fp <= 1'b1;
        m_pend <= 1'b0;
        if (load) begin
          m_val_c <= value; m_dp_c <= dp_in; m_en_c <= digit_en;
        end else if (m_pend) begin
          m_val_c <= m_val_s; m_dp_c <= m_dp_s; m_en_c <= m_en_s;
        end
      end else begin
        e_fp <= 1'b0;
        if (load) m_pend <= 1'b1;
      end
      m_pos <= (m_pos + 1) % FRAME;
    end
  end

  // scoreboard compare, every cycle once the model is anchored by reset
  always @(negedge clk) begin
    if (m_valid) begin
      check("anode", anode, e_anode);
      check("seg_out", seg_out, e_seg);
      check("dp_out", dp_out, e_dp);
      check("frame_pulse", frame_pulse, e_fp);
      check("pending", pending, m_pend);
    end
  end

  // driver tasks
  logic [ND-1:0] cap_an [FRAME];
  logic [6:0] cap_seg [FRAME];
  logic cap_dp [FRAME];

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en);
    @(posedge clk); #1;
    value = v; dp_in = dp; digit_en = en; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic wait_fp(input string what);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_pulse && n < 2 * FRAME);
    if (!frame_pulse) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for frame_pulse after %0d cycles", what, n);
    end
  endtask

  // Samples the frame that starts right after a frame_pulse negedge; index = slot*DIV + cnt.
  task automatic capture();
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      cap_an[k] = anode;
      cap_seg[k] = seg_out;
      cap_dp[k] = dp_out;
    end
  endtask

  initial begin
    logic [3:0] an_on [4];
    int bad, fps, seen_e, seen_b, n;
    an_on = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    clr = 1'b1; load = 1'b0; value = '0; dp_in = '0; digit_en = '0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;

    // idle after reset: dark, pulse every FRAME cycles
    @(posedge clk);
    bad = 0; fps = 0;
    repeat (64) begin
      @(negedge clk);
      if (anode !== 4'hF || seg_out !== 7'h7F) bad++;
      if (frame_pulse) fps++;
    end
    check("idle_dark", bad, 0);
    check("idle_pulses", fps, 2);

    // 12AF with dp on digit 1
    do_load(16'h12AF, 4'b0010, 4'b1111);
    @(negedge clk);
    check("pending_after_load", pending, 1'b1);
    wait_fp("commit_12af");
    capture();
    check("slot0_F", cap_seg[4], 7'b0001110);
    check("slot0_dp", cap_dp[4], 1'b1);
    check("slot1_A", cap_seg[12], 7'b0001000);
    check("slot1_dp", cap_dp[12], 1'b0);
    check("slot2_2", cap_seg[20], 7'b0100100);
    check("slot3_1", cap_seg[28], 7'b1111001);
    for (int d = 0; d < ND; d++) begin
      bad = 0;
      for (int c = 0; c < DIV; c++)
        if (cap_an[d*DIV + c] !== ((c >= BLK) ? an_on[d] : 4'hF)) bad++;
      check($sformatf("slot%0d_anode_window", d), bad, 0);
    end

    // two loads in one frame: last wins, the first never reaches the display
    do_load(16'h1111, 4'b0000, 4'b1111);
    @(posedge clk); #1;
    do_load(16'h2222, 4'b0000, 4'b1111);
    @(negedge clk);
    check("pending_two_loads", pending, 1'b1);
    bad = 0; n = 0;
    do begin
      @(negedge clk);
      n++;
      if (anode === 4'b1110 && seg_out === 7'b1111001) bad++;
    end while (!frame_pulse && n < 2 * FRAME);
    check("fp_before_2222", frame_pulse, 1'b1);
    capture();
    for (int k = 0; k < FRAME; k++)
      if (cap_an[k] === 4'b1110 && cap_seg[k] === 7'b1111001) bad++;
    check("no_1111_shown", bad, 0);
    for (int d = 0; d < ND; d++)
      check($sformatf("slot%0d_2", d), cap_seg[d*DIV + 4], 7'b0100100);

    // partial enable
    do_load(16'h8888, 4'b0000, 4'b0101);
    wait_fp("commit_8888");
    capture();
    bad = 0; seen_e = 0; seen_b = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (cap_an[k] === 4'b1110) seen_e++;
      else if (cap_an[k] === 4'b1011) seen_b++;
      else if (cap_an[k] !== 4'hF) bad++;
    end
    check("en0101_other_anodes", bad, 0);
    check("en0101_slot0_cycles", seen_e, DIV - BLK);
    check("en0101_slot2_cycles", seen_b, DIV - BLK);
    check("en0101_slot1_seg", cap_seg[12], 7'h7F);
    check("slot0_8", cap_seg[4], 7'b0000000);

    // clear during slot2 drive, with an uncommitted load in flight
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (anode !== 4'b1011 && n < 2 * FRAME);
    check("reach_slot2", anode, 4'b1011);
    @(posedge clk); #1;
    value = 16'h5555; dp_in = 4'b1111; digit_en = 4'b1111; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    check("clr_anode", anode, 4'hF);
    check("clr_seg", seg_out, 7'h7F);
    check("clr_dp", dp_out, 1'b1);
    check("clr_pending", pending, 1'b0);
    bad = 0; fps = 0;
    repeat (40) begin
      @(negedge clk);
      if (anode !== 4'hF) bad++;
      if (frame_pulse) fps++;
    end
    check("dark_after_clr", bad, 0);
    check("pulse_after_clr", fps, 1);

    // zero-heavy value: plain build shows every digit, suppression shows only 0 and 1
    do_load(16'h0070, 4'b0000, 4'b1111);
    wait_fp("commit_0070");
    capture();
    check("lz_slot0", cap_seg[4], 7'b1000000);
    check("lz_slot1", cap_seg[12], 7'b1111000);
`ifdef SEG_LZ_BLANK_EN
    check("lz_slot2_anode", cap_an[20], 4'hF);
    check("lz_slot3_seg", cap_seg[28], 7'h7F);
`else
    check("lz_slot2_anode", cap_an[20], 4'b1011);
    check("lz_slot3_seg", cap_seg[28], 7'b1000000);
`endif
    do_load(16'h0070, 4'b1000, 4'b1111);
    wait_fp("commit_0070_dp");
    capture();
    check("dp_slot2_anode", cap_an[20], 4'b1011);
    check("dp_slot3_seg", cap_seg[28], 7'b1000000);
    check("dp_slot3_dp", cap_dp[28], 1'b0);

    // randomized loads and occasional clears against the model
    repeat (1200) begin
      @(posedge clk); #1;
      load = ($urandom_range(0, 11) == 0);
      value = 16'($urandom);
      dp_in = 4'($urandom);
      digit_en = 4'($urandom);
      clr = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk); #1;
    load = 1'b0; clr = 1'b0;
    repeat (4) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
